// File: rtl/com_pkg.sv
`default_nettype none
// ============================================================================
// Module   : com_pkg
// Purpose  : Shared types and constants for the command receiver and the
//            command processor it feeds.
//            rx_state_t - two-state byte-assembly FSM encoding
//            ACK / NACK - response codes agreed with the command processor
// Revision : 1.0 - initial release
// ============================================================================
package com_pkg;

    typedef enum logic {
        IDLE = 1'b0,    // waiting for the high byte
        LOW  = 1'b1     // high byte held, waiting for the low byte
    } rx_state_t;

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;

endpackage
`default_nettype wire

// File: rtl/com_byte_timer.sv
`default_nettype none
// ============================================================================
// Module   : com_byte_timer
// Purpose  : Inter-byte timeout counter. Cleared when a high byte is captured,
//            counts while enabled, saturates at TIMEOUT_CYCLES-1.
// Ports    : clk     in  system clock
//            rst     in  synchronous active-high reset
//            clr     in  restart the count from zero
//            en      in  count this cycle
//            expired out count has reached TIMEOUT_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
module com_byte_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]    c_last = W'(TIMEOUT_CYCLES - 1);

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("com_byte_timer: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    logic [W-1:0] r_count;

    // Holds at the terminal value rather than wrapping, so a stalled FSM can
    // never see the timeout disappear.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_last)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/com_receiver.sv
`default_nettype none
// ============================================================================
// Module   : com_receiver
// Purpose  : Assembles two UART bytes (high first) into a 16-bit command for
//            the command processor and returns its 8-bit response over the
//            UART transmitter.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            rx_rdy, rx_data           received byte from UART
//            clr_rx_rdy                byte consumed (combinational)
//            cmd, cmd_rdy, clr_cmd_rdy command to the processor + handshake
//            frame_err, overrun        one-cycle error pulses
//            resp, send_resp           response byte + transmit request
//            trmt, tx_data, tx_done    UART transmitter handshake
//            tx_busy, resp_sent        transmit status
// Revision : 1.0 - initial release
// ============================================================================
module com_receiver
    import com_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frame_err,
    output logic        overrun,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        tx_busy,
    output logic        resp_sent
);

    rx_state_t   r_state;
    rx_state_t   w_next_state;
    logic        w_capture_hi;
    logic        w_complete;
    logic        w_timeout;
    logic        w_expired;

    logic [7:0]  r_high;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        r_frame_err;
    logic        r_overrun;
    logic        r_trmt;
    logic [7:0]  r_tx_data;
    logic        r_tx_busy;
    logic        r_resp_sent;

    com_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_capture_hi),
        .en      (r_state == LOW),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // RX byte-assembly FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture_hi = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_rdy) begin
                    w_capture_hi = 1'b1;
                    w_next_state = LOW;
                end
            end
            LOW: begin
                // A byte arriving on the expiry cycle takes priority.
                if (rx_rdy) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    // Gated by reset so a byte presented during reset is not acknowledged.
    assign clr_rx_rdy = ~rst & (w_capture_hi | w_complete);

    // ------------------------------------------------------------------
    // Command register and TX handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_high      <= '0;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_trmt      <= 1'b0;
            r_tx_data   <= '0;
            r_tx_busy   <= 1'b0;
            r_resp_sent <= 1'b0;
        end else begin
            if (w_capture_hi) begin
                r_high <= rx_data;
            end
            if (w_complete) begin
                r_cmd <= {r_high, rx_data};
            end

            // Completion beats a same-cycle acknowledge.
            if (w_complete) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end

            r_overrun   <= w_complete & r_cmd_rdy & ~clr_cmd_rdy;
            r_frame_err <= w_timeout;

            r_trmt <= 1'b0;
            if (send_resp && !r_tx_busy) begin
                r_tx_data   <= resp;
                r_trmt      <= 1'b1;
                r_tx_busy   <= 1'b1;
                r_resp_sent <= 1'b0;
            end else if (tx_done && r_tx_busy) begin
                r_tx_busy   <= 1'b0;
                r_resp_sent <= 1'b1;
            end
        end
    end

    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign trmt      = r_trmt;
    assign tx_data   = r_tx_data;
    assign tx_busy   = r_tx_busy;
    assign resp_sent = r_resp_sent;

endmodule
`default_nettype wire
